// File: rtl/controle_concatenacao_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : controle_concatenacao_pkg
//  Description : Shared state encoding, default width and zero seed for the
//                8-bit concatenation datapath controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package controle_concatenacao_pkg;

    // Controller states, 2-bit encoded
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } estado_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_WIDTH     = 32;

    // Initial value of the concatenation register; also feeds the
    // constant-zero generator, so it is kept at the widest legal size.
    localparam logic [MAX_WIDTH-1:0] ZERO_SEED = '0;

endpackage
`default_nettype wire

// File: rtl/controle_concatenacao_contador_bits.sv
`default_nettype none
// ============================================================================
//  Module      : contador_bits
//  Description : Bit counter for the serial shift phase. Clears on request,
//                advances on enable and wraps to 0 after WIDTH-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_bits #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int              CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_count;

    // Count accepted bits; clear has priority over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= (r_count == C_LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign tc = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/controle_concatenacao.sv
`default_nettype none
// ============================================================================
//  Module      : controle_concatenacao
//  Description : Sequencing controller for the concatenation datapath. Seeds
//                the register with zero, shifts in WIDTH serial bits (MSB
//                first) and offers the assembled word on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module controle_concatenacao
    import controle_concatenacao_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] dado_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel_inicial,
    output logic             busy
);

    estado_t          r_state;
    estado_t          w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic             r_bit_ready;
    logic             r_out_valid;
    logic             r_sel_inicial;
    logic             r_busy;
    logic             w_xfer;
    logic             w_out_xfer;
    logic             w_tc;

    // A bit is consumed only in SHIFT and never alongside abort
    assign w_xfer     = (r_state == SHIFT) && bit_valid && !abort;
    assign w_out_xfer = (r_state == DONE) && out_ready;

    contador_bits #(
        .WIDTH (WIDTH)
    ) u_contador_bits (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort || (r_state == INIT)),
        .en    (w_xfer),
        .tc    (w_tc)
    );

    // Next-state decode; abort overrides every other input
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_state_nxt = INIT;
                INIT:    w_state_nxt = SHIFT;
                SHIFT:   if (bit_valid && w_tc) w_state_nxt = DONE;
                DONE:    if (out_ready) w_state_nxt = start ? INIT : IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State, shift register and outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_bit_ready   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_sel_inicial <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (abort) begin
                r_shift <= '0;
            end else if (r_state == INIT) begin
                r_shift <= ZERO_SEED[WIDTH-1:0];
            end else if (w_xfer) begin
                r_shift <= {r_shift[WIDTH-2:0], bit_in};
            end else if (w_out_xfer) begin
                // word delivered: register reads zero outside a word
                r_shift <= '0;
            end
            r_bit_ready   <= (w_state_nxt == SHIFT);
            r_out_valid   <= (w_state_nxt == DONE);
            r_sel_inicial <= (w_state_nxt == INIT);
            r_busy        <= (w_state_nxt != IDLE);
        end
    end

    assign bit_ready   = r_bit_ready;
    assign out_valid   = r_out_valid;
    assign sel_inicial = r_sel_inicial;
    assign busy        = r_busy;
    assign dado_out    = r_shift;

endmodule
`default_nettype wire

// File: tb/tb_controle_concatenacao.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controle_concatenacao
//  Description : Self-checking bench for controle_concatenacao: table of
//                word vectors plus hand-written abort, reset and
//                back-to-back sequences, with a scoreboard of expected words.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_controle_concatenacao;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic         bit_in;
    logic         bit_valid;
    logic         bit_ready;
    logic [W-1:0] dado_out;
    logic         out_valid;
    logic         out_ready;
    logic         sel_inicial;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t_start  = 0;

    logic [W-1:0] sb_q[$];

    typedef struct {
        logic [7:0] word;
        int         gap_at;
        int         gap_len;
        int         ready_delay;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    controle_concatenacao #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .dado_out    (dado_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sel_inicial (sel_inicial),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Request a word; start is sampled at the coming edge
    task automatic start_word(input logic [7:0] word, input bit push);
        start = 1'b1;
        tick();
        start = 1'b0;
        t_start = cyc - 1;
        check("init sel_inicial", sel_inicial, 1);
        check("init busy", busy, 1);
        check("init bit_ready", bit_ready, 0);
        if (push) sb_q.push_back(word);
    endtask

    // Called while in INIT: move to SHIFT and feed the bits MSB first
    task automatic send_bits(input logic [7:0] word, input int gap_at, input int gap_len);
        tick();
        check("shift bit_ready", bit_ready, 1);
        check("shift sel_inicial", sel_inicial, 0);
        for (int i = 0; i < W; i++) begin
            bit_in    = word[7-i];
            bit_valid = 1'b1;
            tick();
            if (i + 1 == gap_at) begin
                bit_valid = 1'b0;
                bit_in    = 1'b1;
                repeat (gap_len) tick();
            end
        end
        bit_valid = 1'b0;
    endtask

    // Wait for the word, stall the consumer, then accept it
    task automatic recv_word(input int exp_lat, input int ready_delay, input bit start_next);
        int           waited;
        logic [W-1:0] exp;
        waited = 0;
        while (!out_valid && waited < 50) begin
            tick();
            waited++;
        end
        if (!out_valid) begin
            check("out_valid timeout", 0, 1);
            return;
        end
        check("out_valid latency", cyc - t_start, exp_lat);
        if (sb_q.size() == 0) begin
            check("scoreboard empty", 1, 0);
            exp = '0;
        end else begin
            exp = sb_q.pop_front();
        end
        check("dado_out", dado_out, exp);
        out_ready = 1'b0;
        for (int i = 0; i < ready_delay; i++) begin
            tick();
            check("hold out_valid", out_valid, 1);
            check("hold dado_out", dado_out, exp);
        end
        out_ready = 1'b1;
        start     = start_next;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("after xfer out_valid", out_valid, 0);
        if (start_next) begin
            t_start = cyc - 1;
            check("b2b sel_inicial", sel_inicial, 1);
            check("b2b busy", busy, 1);
        end else begin
            check("after xfer busy", busy, 0);
            check("after xfer dado_out", dado_out, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen_valid;
        logic [7:0] ab_word;

        vecs[0] = '{8'hA5, 0, 0, 0};
        vecs[1] = '{8'hA5, 4, 2, 0};
        vecs[2] = '{8'hA5, 0, 0, 5};
        vecs[3] = '{8'h00, 0, 0, 1};
        vecs[4] = '{8'h3C, 1, 1, 0};
        vecs[5] = '{8'h81, 7, 3, 2};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;

        // Reset held for three cycles
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset bit_ready", bit_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset sel_inicial", sel_inicial, 0);
        check("reset busy", busy, 0);
        check("reset dado_out", dado_out, 0);

        // Bits offered in IDLE are ignored
        bit_valid = 1'b1; bit_in = 1'b1;
        repeat (3) tick();
        check("idle bit_ready", bit_ready, 0);
        check("idle busy", busy, 0);
        check("idle dado_out", dado_out, 0);
        bit_valid = 1'b0;

        // Table-driven words
        for (int v = 0; v < 6; v++) begin
            start_word(vecs[v].word, 1'b1);
            send_bits(vecs[v].word, vecs[v].gap_at, vecs[v].gap_len);
            recv_word(10 + vecs[v].gap_len, vecs[v].ready_delay, 1'b0);
        end

        // Abort coincident with the 6th bit
        ab_word = 8'hA5;
        start_word(8'h00, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            bit_in = ab_word[7-i]; bit_valid = 1'b1;
            tick();
        end
        bit_in = ab_word[2]; abort = 1'b1;
        tick();
        abort = 1'b0; bit_valid = 1'b0;
        check("abort busy", busy, 0);
        check("abort dado_out", dado_out, 0);
        check("abort out_valid", out_valid, 0);
        check("abort bit_ready", bit_ready, 0);
        // Counter must restart from zero for the next word
        start_word(8'h96, 1'b1);
        send_bits(8'h96, 0, 0);
        recv_word(10, 0, 1'b0);

        // Asynchronous reset after three bits
        start_word(8'h00, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'b1; bit_valid = 1'b1;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", busy, 0);
        check("async rst bit_ready", bit_ready, 0);
        check("async rst dado_out", dado_out, 0);
        tick();
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        bit_valid = 1'b0;
        check("post rst no out_valid", seen_valid, 0);
        check("post rst busy", busy, 0);

        // Back-to-back words, second all ones
        start_word(8'h5A, 1'b1);
        send_bits(8'h5A, 0, 0);
        recv_word(10, 0, 1'b1);
        sb_q.push_back(8'hFF);
        send_bits(8'hFF, 0, 0);
        recv_word(10, 0, 1'b0);

        check("scoreboard drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
